// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite command master.
package axi_lite_pkg;

  // Master sequencer states: one read path, one write path and a shared
  // response-hold state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    RSP   = 3'd5
  } cmd_state_e;

  // AXI response codes used by the master.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // States where the master waits on the slave and the timeout runs.
  function automatic logic is_wait_state(input cmd_state_e s);
    return (s == RADDR) || (s == RDATA) || (s == WREQ) || (s == WRESP);
  endfunction

endpackage

// File: rtl/axi_lite_wait_timer.sv
// Per-state wait counter: cleared on state entry, counts while enabled and
// flags expiry when the count reaches TIMEOUT. TIMEOUT = 0 never expires.
module axi_lite_wait_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic aclk,
  input  logic areset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Count wait cycles; hold at the limit so expiry stays asserted.
  always_ff @(posedge aclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!areset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or
// write transaction and returns a registered response with optional timeout.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,   // 32 or 64
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic                  rsp_timeout,
  // AW
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  // W
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  // B
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AR
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  // R
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  cmd_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                write_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                timeout_q;
  logic                aw_done_q, w_done_q;
  logic                aw_hs, w_hs;
  logic                wait_state;
  logic                expired;

  assign wait_state = is_wait_state(state_q);

  // Wait counter restarts on every state change and runs only while waiting
  // on the slave.
  axi_lite_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear    (state_d != state_q),
    .enable   (wait_state),
    .expired  (expired)
  );

  // Next-state and handshake outputs; expiry overrides any handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_write ? WREQ : RADDR;
      end
      RADDR: begin
        if (expired) begin
          state_d = RSP;
        end else begin
          arvalid = 1'b1;
          if (arready) state_d = RDATA;
        end
      end
      RDATA: begin
        if (expired) begin
          state_d = RSP;
        end else begin
          rready = 1'b1;
          if (rvalid) state_d = RSP;
        end
      end
      WREQ: begin
        if (expired) begin
          state_d = RSP;
        end else begin
          awvalid = !aw_done_q;
          wvalid  = !w_done_q;
          aw_hs   = awvalid && awready;
          w_hs    = wvalid && wready;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
        end
      end
      WRESP: begin
        if (expired) begin
          state_d = RSP;
        end else begin
          bready = 1'b1;
          if (bvalid) state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data buses are zero whenever their valid is low.
  assign araddr = arvalid ? addr_q  : '0;
  assign awaddr = awvalid ? addr_q  : '0;
  assign wdata  = wvalid  ? wdata_q : '0;
  assign wstrb  = wvalid  ? wstrb_q : '0;

  // State register, command capture, handshake flags and response capture.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      timeout_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        RADDR: begin
          if (expired) begin
            resp_q    <= SLVERR;
            timeout_q <= 1'b1;
          end
        end
        RDATA: begin
          if (expired) begin
            resp_q    <= SLVERR;
            timeout_q <= 1'b1;
          end else if (rvalid) begin
            rdata_q <= rdata;
            resp_q  <= rresp;
          end
        end
        WREQ: begin
          if (expired) begin
            resp_q    <= SLVERR;
            timeout_q <= 1'b1;
          end
          if (state_d != WREQ) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        WRESP: begin
          if (expired) begin
            resp_q    <= SLVERR;
            timeout_q <= 1'b1;
          end else if (bvalid) begin
            resp_q <= bresp;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_write   = write_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: directed AXI slave behaviour
// with a response scoreboard.
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        write;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;

  always #5 aclk = ~aclk;

  axi_lite_cmd_master #(
    .ADDR_W (32), .DATA_W (32), .TIMEOUT (8)
  ) dut (
    .aclk (aclk), .areset_n (areset_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .rsp_write (rsp_write), .rsp_timeout (rsp_timeout),
    .awaddr (awaddr), .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .araddr (araddr), .arvalid (arvalid), .arready (arready),
    .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready)
  );

  // Count completed AXI handshakes on each channel.
  always @(posedge aclk) begin
    if (areset_n) begin
      if (arvalid && arready) ar_cnt++;
      if (awvalid && awready) aw_cnt++;
      if (wvalid && wready)   w_cnt++;
      if (bvalid && bready)   b_cnt++;
      if (rvalid && rready)   r_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Present one command at a negedge; returns at the negedge after acceptance.
  task automatic drive_cmd(input string tag, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input exp_t e, input bit push);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    if (push) exp_q.push_back(e);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare it to the scoreboard, complete it.
  task automatic wait_rsp(input string tag);
    int   n = 0;
    exp_t e;
    while (!rsp_valid && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    if (rsp_valid) begin
      check({tag, "_sb_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_rdata"},   rsp_rdata,   e.rdata);
        check({tag, "_resp"},    rsp_resp,    e.resp);
        check({tag, "_write"},   rsp_write,   e.write);
        check({tag, "_timeout"}, rsp_timeout, e.timeout);
      end
      rsp_ready = 1'b1;
      @(negedge aclk);
      rsp_ready = 1'b0;
      check({tag, "_idle_after"}, {cmd_ready, rsp_valid}, 2'b10);
    end
  endtask

  // Read with programmable AR and R delays from a simple slave.
  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] rr,
                         input int ad, input int rd);
    exp_t e;
    e = '{d, rr, 1'b0, 1'b0};
    drive_cmd(tag, 1'b0, a, 32'h0, 4'h0, e, 1'b1);
    check({tag, "_araddr"}, araddr, a);
    repeat (ad) @(negedge aclk);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    repeat (rd) @(negedge aclk);
    rvalid = 1'b1; rdata = d; rresp = rr;
    @(negedge aclk);
    rvalid = 1'b0; rdata = '0; rresp = '0;
    wait_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, hi;
    int   c_ar, c_aw, c_w, c_b, c_r;
    exp_t e;

    areset_n = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);

    // Reset state: only cmd_ready high, all buses zero.
    check("rst_ready", cmd_ready, 1);
    check("rst_ctrl", {arvalid, awvalid, wvalid, bready, rready, rsp_valid,
                       rsp_write, rsp_timeout, rsp_resp}, 0);
    check("rst_bus", {araddr, awaddr, wdata, wstrb}, 0);
    check("rst_rdata", rsp_rdata, 0);
    areset_n = 1'b1;
    @(negedge aclk);

    // Read with zero-wait slave: response on the third cycle.
    c_ar = ar_cnt; c_r = r_cnt;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hECE00593; rresp = 2'b00;
    e = '{32'hECE00593, 2'b00, 1'b0, 1'b0};
    drive_cmd("rd0", 1'b0, 32'h4, 32'h0, 4'h0, e, 1'b1);
    check("rd0_araddr", {arvalid, araddr}, {1'b1, 32'h4});
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge aclk);
      lat++;
    end
    check("rd0_latency", lat, 3);
    wait_rsp("rd0");
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    check("rd0_ar_hs", ar_cnt - c_ar, 1);
    check("rd0_r_hs", r_cnt - c_r, 1);

    // Write with AW accepted two cycles before W.
    c_aw = aw_cnt; c_w = w_cnt; c_b = b_cnt;
    e = '{32'h0, 2'b00, 1'b1, 1'b0};
    drive_cmd("wr0", 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, e, 1'b1);
    check("wr0_both_valid", {awvalid, wvalid}, 2'b11);
    check("wr0_awaddr", awaddr, 32'h8);
    check("wr0_wdata", {wdata, wstrb}, {32'hA5A5A5A5, 4'hF});
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    check("wr0_aw_first", {awvalid, wvalid}, 2'b01);
    @(negedge aclk);
    check("wr0_w_held", {awvalid, wvalid}, 2'b01);
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    check("wr0_wresp", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge aclk);
    bvalid = 1'b0;
    wait_rsp("wr0");
    check("wr0_aw_hs", aw_cnt - c_aw, 1);
    check("wr0_w_hs", w_cnt - c_w, 1);
    check("wr0_b_hs", b_cnt - c_b, 1);

    // Write with same-cycle AW/W handshakes and an error response.
    awready = 1'b1; wready = 1'b1;
    e = '{32'h0, 2'b10, 1'b1, 1'b0};
    drive_cmd("wr1", 1'b1, 32'hC, 32'h12345678, 4'h3, e, 1'b1);
    check("wr1_both_valid", {awvalid, wvalid, wstrb}, {2'b11, 4'h3});
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    check("wr1_wresp", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'b00;
    wait_rsp("wr1");

    // Read timeout with arready stuck low, then a held response.
    c_ar = ar_cnt;
    e = '{32'h0, 2'b10, 1'b0, 1'b1};
    drive_cmd("to0", 1'b0, 32'h10, 32'h0, 4'h0, e, 1'b1);
    hi = 0; lat = 0;
    while (!rsp_valid && lat < 30) begin
      if (arvalid) hi++;
      @(negedge aclk);
      lat++;
    end
    check("to0_arvalid_cycles", hi, 8);
    check("to0_ar_hs", ar_cnt - c_ar, 0);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_state", {rsp_valid, cmd_ready, arvalid, awvalid}, 4'b1000);
      check("hold_rsp", {rsp_rdata, rsp_resp, rsp_write, rsp_timeout},
            {exp_q[0].rdata, exp_q[0].resp, exp_q[0].write, exp_q[0].timeout});
      @(negedge aclk);
    end
    cmd_valid = 1'b0; cmd_write = 1'b0;
    wait_rsp("to0");

    // Reads with random data, response codes and slave delays.
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("rnd%0d", i), 32'h100 + 32'(i * 4), $urandom,
              2'($urandom_range(0, 3)), $urandom_range(0, 4),
              $urandom_range(0, 4));
    end

    // Reset during WRESP aborts the write without a response.
    awready = 1'b1; wready = 1'b1;
    e = '{32'h0, 2'b00, 1'b1, 1'b0};
    drive_cmd("abt", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, e, 1'b0);
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    check("abt_in_wresp", bready, 1);
    areset_n = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    check("abt_idle", {cmd_ready, rsp_valid, bready}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("abt_no_rsp", {cmd_ready, rsp_valid}, 2'b10);
    end
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; legal values 32 or 64.
REQ-003 SHALL have parameter TIMEOUT, default 256, cycles allowed per wait state; 0 disables the timeout.
REQ-004 SHALL have port aclk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port areset_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR_W, cmd_wdata in DATA_W, cmd_wstrb in DATA_W/8: the command request channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_W, rsp_resp out 2, rsp_write out 1, rsp_timeout out 1: the response channel.
REQ-008 SHALL have AW ports awaddr out ADDR_W, awvalid out 1, awready in 1.
REQ-009 SHALL have W ports wdata out DATA_W, wstrb out DATA_W/8, wvalid out 1, wready in 1.
REQ-010 SHALL have B ports bresp in 2, bvalid in 1, bready out 1.
REQ-011 SHALL have AR ports araddr out ADDR_W, arvalid out 1, arready in 1.
REQ-012 SHALL have R ports rdata in DATA_W, rresp in 2, rvalid in 1, rready out 1.

Function
REQ-013 SHALL implement states IDLE, RADDR, RDATA, WREQ, WRESP and RSP.
REQ-014 SHALL assert cmd_ready only in IDLE.
REQ-015 SHALL register the addr, wdata, wstrb and write fields of a command on the cmd_valid&&cmd_ready cycle, then go to WREQ if write=1, else RADDR.
REQ-016 RADDR SHALL drive arvalid=1 with the registered addr and SHALL go to RDATA on arvalid&&arready.
REQ-017 RDATA SHALL drive rready=1; on rvalid it SHALL capture rdata and rresp and go to RSP.
REQ-018 WREQ SHALL assert awvalid and wvalid together, and each SHALL fall independently after its own handshake.
REQ-019 WREQ SHALL use sticky aw_done and w_done flags, go to WRESP once both are set (same-cycle handshakes allowed), and clear both flags on exit.
REQ-020 WRESP SHALL drive bready=1; on bvalid it SHALL capture bresp and go to RSP.
REQ-021 RSP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then go to IDLE; the shortest command-to-response latency SHALL be 3 cycles.
REQ-022 rsp_rdata SHALL be 0 for writes and rsp_write SHALL echo the command type.
REQ-023 Outside their driving states, AXI address and data outputs SHALL be 0 and valid/ready outputs SHALL be 0.
REQ-024 With TIMEOUT>0, a wait counter SHALL clear on each state entry and increment every cycle in RADDR, RDATA, WREQ and WRESP.
REQ-025 When the wait counter reaches TIMEOUT, the block SHALL drop all AXI valid/ready outputs, set rsp_resp=2'b10 and rsp_timeout=1, and go to RSP; otherwise rsp_timeout=0.
REQ-026 A timeout SHALL take precedence over a handshake completing in the same cycle.
REQ-027 The block SHALL have at most one transaction outstanding; cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-028 While areset_n=0 at a clock edge, the state SHALL become IDLE and counters, flags and captured registers SHALL clear to 0.
REQ-029 After reset, all outputs SHALL be 0 except cmd_ready=1.
REQ-030 A reset mid-transaction SHALL abort the transaction with no response issued.

Structure
REQ-031 The state enum and the AXI resp constants OKAY=2'b00 and SLVERR=2'b10 SHALL live in axi_lite_pkg.
REQ-032 The timeout counter SHALL be a sub-module, axi_lite_wait_timer, with inputs clear and enable and output expired.
REQ-033 Response registers SHALL be flops, with no combinational path from AXI inputs to rsp_*.

Verification
REQ-034 Read at addr 0x4 with arready=1 and rvalid=1, rdata=0xECE00593 and rresp=0 SHALL give rsp_valid on cycle 3 with rdata 0xECE00593, resp 0, rsp_write 0.
REQ-035 Write addr 0x8, data 0xA5A5A5A5, strb 0xF, with awready 2 cycles before wready and bresp=0 SHALL give awvalid dropping first, exactly one of each handshake, and rsp resp 0.
REQ-036 Write with the AW and W handshakes in the same cycle followed by bresp=2'b10 SHALL give rsp_resp 2'b10 and rsp_timeout 0.
REQ-037 TIMEOUT=8 with arready held at 0 SHALL drop arvalid after 8 cycles and give rsp_resp 2'b10, rsp_timeout 1.
REQ-038 rsp_ready held at 0 for 5 cycles SHALL keep rsp_* stable with cmd_ready=0 throughout.
REQ-039 areset_n pulsed low during WRESP SHALL return the block to IDLE with cmd_ready=1 and no rsp_valid.
